// File: rtl/xdma_pkg.sv
// Shared XDMA definitions for the receive-side configuration frame assembler:
// derived width helpers, frame header layouts and the assembler state enum.
package xdma_pkg;

  // Default widths the header structs are laid out for.
  localparam int DefDataWidth     = 512;
  localparam int DefAddrWidth     = 48;
  localparam int DefIdWidth       = 4;
  localparam int DefFrameLenWidth = 4;

  // Payload bits carried by the first frame after its full header.
  function automatic int first_pw(input int dw, input int flw, input int idw, input int aw);
    return dw - 1 - flw - idw - 2 * aw;
  endfunction

  // Payload bits carried by each continuation frame (short header only).
  function automatic int rem_pw(input int dw, input int flw);
    return dw - 1 - flw;
  endfunction

  // Width of the fully concatenated configuration payload.
  function automatic int payload_w(input int dw, input int flw, input int idw,
                                   input int aw, input int mf);
    return first_pw(dw, flw, idw, aw) + (mf - 1) * rem_pw(dw, flw);
  endfunction

  // First-frame header, LSB first: dma_type, frame_length, dma_id, reader, writer.
  typedef struct packed {
    logic [DefAddrWidth-1:0]     writer_addr;
    logic [DefAddrWidth-1:0]     reader_addr;
    logic [DefIdWidth-1:0]       dma_id;
    logic [DefFrameLenWidth-1:0] frame_length;
    logic                        dma_type;
  } xdma_cfg_first_hdr_t;

  // Continuation-frame header, LSB first: dma_type, frame_length.
  typedef struct packed {
    logic [DefFrameLenWidth-1:0] frame_length;
    logic                        dma_type;
  } xdma_cfg_cont_hdr_t;

  typedef enum logic [1:0] {
    ASM_IDLE    = 2'd0,
    ASM_COLLECT = 2'd1,
    ASM_OUTPUT  = 2'd2
  } xdma_cfg_asm_state_e;

endpackage

// File: rtl/xdma_cfg_frame_assembler_parser.sv
// Combinational splitter for one configuration frame: exposes every header
// field of the first-frame layout plus both possible payload slices.
module xdma_cfg_frame_assembler_parser
  import xdma_pkg::*;
#(
  parameter int DataWidth     = 512,
  parameter int AddrWidth     = 48,
  parameter int IdWidth       = 4,
  parameter int FrameLenWidth = 4,
  localparam int FirstPW      = first_pw(DataWidth, FrameLenWidth, IdWidth, AddrWidth),
  localparam int RemPW        = rem_pw(DataWidth, FrameLenWidth)
) (
  input  logic [DataWidth-1:0]     frame_i,
  output logic                     dma_type_o,
  output logic [FrameLenWidth-1:0] frame_len_o,
  output logic [IdWidth-1:0]       dma_id_o,
  output logic [AddrWidth-1:0]     reader_addr_o,
  output logic [AddrWidth-1:0]     writer_addr_o,
  output logic [FirstPW-1:0]       first_payload_o,
  output logic [RemPW-1:0]         rem_payload_o
);

  localparam int LenLsb    = 1;
  localparam int IdLsb     = LenLsb + FrameLenWidth;
  localparam int ReaderLsb = IdLsb + IdWidth;
  localparam int WriterLsb = ReaderLsb + AddrWidth;
  localparam int FirstPLsb = WriterLsb + AddrWidth;

  assign dma_type_o      = frame_i[0];
  assign frame_len_o     = frame_i[LenLsb +: FrameLenWidth];
  assign dma_id_o        = frame_i[IdLsb +: IdWidth];
  assign reader_addr_o   = frame_i[ReaderLsb +: AddrWidth];
  assign writer_addr_o   = frame_i[WriterLsb +: AddrWidth];
  assign first_payload_o = frame_i[FirstPLsb +: FirstPW];
  // Continuation payload starts right after the short header.
  assign rem_payload_o   = frame_i[IdLsb +: RemPW];

endmodule

// File: rtl/xdma_cfg_frame_assembler.sv
// Receive-side assembler for multi-frame inter-cluster XDMA configurations.
// Collects 1..MaxFrames frames, checks their headers and presents one wide
// configuration word on a valid/ready interface.
// Optional macro XDMA_CFG_ASM_TIMEOUT_EN: abort a partial configuration when
// no continuation frame arrives within TimeoutCycles.
module xdma_cfg_frame_assembler
  import xdma_pkg::*;
#(
  parameter int DataWidth     = 512,
  parameter int AddrWidth     = 48,
  parameter int IdWidth       = 4,
  parameter int FrameLenWidth = 4,
  parameter int MaxFrames     = 4,
  parameter int TimeoutCycles = 1024,
  localparam int FirstPW      = first_pw(DataWidth, FrameLenWidth, IdWidth, AddrWidth),
  localparam int RemPW        = rem_pw(DataWidth, FrameLenWidth),
  localparam int PayloadWidth = payload_w(DataWidth, FrameLenWidth, IdWidth, AddrWidth, MaxFrames)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DataWidth-1:0]     frame_i,
  input  logic                     frame_valid_i,
  output logic                     frame_ready_o,
  output logic                     cfg_valid_o,
  input  logic                     cfg_ready_i,
  output logic                     dma_type_o,
  output logic [IdWidth-1:0]       dma_id_o,
  output logic [AddrWidth-1:0]     reader_addr_o,
  output logic [AddrWidth-1:0]     writer_addr_o,
  output logic [FrameLenWidth-1:0] num_frames_o,
  output logic [PayloadWidth-1:0]  payload_o,
  output logic                     error_o
);

  localparam logic [FrameLenWidth-1:0] MaxLen = FrameLenWidth'(MaxFrames);
  localparam logic [FrameLenWidth-1:0] OneLen = FrameLenWidth'(1);

  // Parsed view of the incoming frame.
  logic                     p_type;
  logic [FrameLenWidth-1:0] p_len;
  logic [IdWidth-1:0]       p_id;
  logic [AddrWidth-1:0]     p_raddr;
  logic [AddrWidth-1:0]     p_waddr;
  logic [FirstPW-1:0]       p_first_pay;
  logic [RemPW-1:0]         p_rem_pay;

  xdma_cfg_frame_assembler_parser #(
    .DataWidth     (DataWidth),
    .AddrWidth     (AddrWidth),
    .IdWidth       (IdWidth),
    .FrameLenWidth (FrameLenWidth)
  ) u_parser (
    .frame_i         (frame_i),
    .dma_type_o      (p_type),
    .frame_len_o     (p_len),
    .dma_id_o        (p_id),
    .reader_addr_o   (p_raddr),
    .writer_addr_o   (p_waddr),
    .first_payload_o (p_first_pay),
    .rem_payload_o   (p_rem_pay)
  );

  xdma_cfg_asm_state_e      state_q, state_d;
  logic [FrameLenWidth-1:0] cnt_q, cnt_d;
  logic [FrameLenWidth-1:0] len_q;
  logic                     type_q;
  logic [IdWidth-1:0]       id_q;
  logic [AddrWidth-1:0]     raddr_q;
  logic [AddrWidth-1:0]     waddr_q;
  logic [FirstPW-1:0]       first_pay_q;
  logic                     error_q, error_d;
  logic                     first_load;
  logic                     cont_load;
  logic                     frame_fire;
  logic                     timeout_hit;
  logic [FrameLenWidth-1:0] cnt_inc;

  assign frame_ready_o = (state_q != ASM_OUTPUT);
  assign frame_fire    = frame_valid_i & frame_ready_o;
  assign cnt_inc       = cnt_q + OneLen;

`ifdef XDMA_CFG_ASM_TIMEOUT_EN
  localparam int TimerW = $clog2(TimeoutCycles + 1);
  logic [TimerW-1:0] timer_q;

  assign timeout_hit = (state_q == ASM_COLLECT) && !frame_fire &&
                       (timer_q == TimerW'(TimeoutCycles - 1));

  // Idle-cycle counter while waiting for a continuation frame.
  always_ff @(posedge clk_i) begin
    if (rst_i || (state_q != ASM_COLLECT) || frame_fire) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TimerW'(1);
    end
  end
`else
  logic timeout_unused;
  assign timeout_unused = (TimeoutCycles != 0);
  assign timeout_hit    = 1'b0;
`endif

  // State register, frame counter and registered error pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ASM_IDLE;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  // Next-state logic: header checks and frame accounting.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    error_d    = 1'b0;
    first_load = 1'b0;
    cont_load  = 1'b0;
    unique case (state_q)
      ASM_IDLE: begin
        if (frame_fire) begin
          if ((p_len == '0) || (p_len > MaxLen)) begin
            error_d = 1'b1;
          end else begin
            first_load = 1'b1;
            cnt_d      = OneLen;
            state_d    = (p_len == OneLen) ? ASM_OUTPUT : ASM_COLLECT;
          end
        end
      end
      ASM_COLLECT: begin
        if (frame_fire) begin
          if ((p_type != type_q) || (p_len != len_q)) begin
            error_d = 1'b1;
            cnt_d   = '0;
            state_d = ASM_IDLE;
          end else begin
            cont_load = 1'b1;
            cnt_d     = cnt_inc;
            if (cnt_inc == len_q) begin
              state_d = ASM_OUTPUT;
            end
          end
        end else if (timeout_hit) begin
          error_d = 1'b1;
          cnt_d   = '0;
          state_d = ASM_IDLE;
        end
      end
      ASM_OUTPUT: begin
        if (cfg_ready_i) begin
          state_d = ASM_IDLE;
        end
      end
      default: begin
        state_d = ASM_IDLE;
      end
    endcase
  end

  // Header fields and first payload are captured from the first frame only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      len_q       <= '0;
      type_q      <= 1'b0;
      id_q        <= '0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      first_pay_q <= '0;
    end else if (first_load) begin
      len_q       <= p_len;
      type_q      <= p_type;
      id_q        <= p_id;
      raddr_q     <= p_raddr;
      waddr_q     <= p_waddr;
      first_pay_q <= p_first_pay;
    end
  end

  assign payload_o[FirstPW-1:0] = first_pay_q;

  // One register per continuation slot; a new first frame wipes every slot so
  // shorter configurations never expose bits from an earlier one.
  for (genvar gi = 1; gi < MaxFrames; gi++) begin : g_slot
    logic [RemPW-1:0] slot_q;

    // Slot capture on the continuation frame whose index matches this slot.
    always_ff @(posedge clk_i) begin
      if (rst_i || first_load) begin
        slot_q <= '0;
      end else if (cont_load && (cnt_q == FrameLenWidth'(gi))) begin
        slot_q <= p_rem_pay;
      end
    end

    assign payload_o[FirstPW + (gi - 1) * RemPW +: RemPW] = slot_q;
  end

  assign cfg_valid_o   = (state_q == ASM_OUTPUT);
  assign error_o       = error_q;
  assign dma_type_o    = type_q;
  assign dma_id_o      = id_q;
  assign reader_addr_o = raddr_q;
  assign writer_addr_o = waddr_q;
  assign num_frames_o  = cnt_q;

endmodule

// File: tb/tb_xdma_cfg_frame_assembler.sv
// Bench for xdma_cfg_frame_assembler: directed frame sequences, a reference
// model built from the frame layout rules, and a per-cycle output compare.
module tb_xdma_cfg_frame_assembler;

  localparam int DW  = 512;
  localparam int FPW = 407;
  localparam int RPW = 507;
  localparam int PW  = 1928;
  localparam int TMO = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [DW-1:0] frame_i = '0;
  logic          frame_valid_i = 1'b0;
  logic          frame_ready_o;
  logic          cfg_valid_o;
  logic          cfg_ready_i = 1'b1;
  logic          dma_type_o;
  logic [3:0]    dma_id_o;
  logic [47:0]   reader_addr_o;
  logic [47:0]   writer_addr_o;
  logic [3:0]    num_frames_o;
  logic [PW-1:0] payload_o;
  logic          error_o;

  xdma_cfg_frame_assembler #(.TimeoutCycles(TMO)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .frame_i       (frame_i),
    .frame_valid_i (frame_valid_i),
    .frame_ready_o (frame_ready_o),
    .cfg_valid_o   (cfg_valid_o),
    .cfg_ready_i   (cfg_ready_i),
    .dma_type_o    (dma_type_o),
    .dma_id_o      (dma_id_o),
    .reader_addr_o (reader_addr_o),
    .writer_addr_o (writer_addr_o),
    .num_frames_o  (num_frames_o),
    .payload_o     (payload_o),
    .error_o       (error_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int err_seen = 0;
  int valid_seen = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] fold(input logic [PW-1:0] v);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < PW; i++) r[i % 64] = r[i % 64] ^ v[i];
    return r;
  endfunction

  task automatic chkp(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual_fold=%0h required_fold=%0h", nm, fold(act), fold(exp));
    end
  endtask

  // Frame builders following the documented bit layouts.
  function automatic logic [DW-1:0] mk_first(input logic t, input logic [3:0] l, input logic [3:0] id,
                                             input logic [47:0] ra, input logic [47:0] wa,
                                             input logic [FPW-1:0] pay);
    return {pay, wa, ra, id, l, t};
  endfunction

  function automatic logic [DW-1:0] mk_next(input logic t, input logic [3:0] l, input logic [RPW-1:0] pay);
    return {pay, l, t};
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic          t;
    logic [3:0]    id;
    logic [47:0]   ra;
    logic [47:0]   wa;
    logic [3:0]    n;
    logic [PW-1:0] pay;
  } cfg_t;

  cfg_t          exp_q[$];
  logic          exp_err = 1'b0;
  logic          m_active = 1'b0;
  int            m_got = 0;
  int            m_len = 0;
  int            m_idle = 0;
  cfg_t          m_cur;

  always @(posedge clk_i) begin
    logic          e;
    logic          t;
    int            l;
    e = 1'b0;
    if (rst_i) begin
      exp_q.delete();
      m_active = 1'b0;
      m_got = 0;
      m_idle = 0;
    end else begin
      if (cfg_valid_o && cfg_ready_i && exp_q.size() != 0) void'(exp_q.pop_front());
      if (frame_valid_i && frame_ready_o) begin
        t = frame_i[0];
        l = int'(frame_i[4:1]);
        m_idle = 0;
        if (!m_active) begin
          if (l == 0 || l > 4) begin
            e = 1'b1;
          end else begin
            m_cur.t   = t;
            m_cur.id  = frame_i[8:5];
            m_cur.ra  = frame_i[56:9];
            m_cur.wa  = frame_i[104:57];
            m_cur.pay = '0;
            m_cur.pay[FPW-1:0] = frame_i[DW-1:105];
            m_len = l;
            m_got = 1;
            m_active = 1'b1;
          end
        end else if (t != m_cur.t || l != m_len) begin
          e = 1'b1;
          m_active = 1'b0;
        end else begin
          m_cur.pay[FPW + (m_got - 1) * RPW +: RPW] = frame_i[DW-1:5];
          m_got++;
        end
        if (m_active && m_got == m_len) begin
          m_cur.n = 4'(m_len);
          exp_q.push_back(m_cur);
          m_active = 1'b0;
        end
      end else if (m_active) begin
`ifdef XDMA_CFG_ASM_TIMEOUT_EN
        m_idle++;
        if (m_idle == TMO) begin
          e = 1'b1;
          m_active = 1'b0;
          m_idle = 0;
        end
`endif
      end
    end
    exp_err = e;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (error_o) err_seen++;
      if (cfg_valid_o) valid_seen++;
      chk("error_o", 64'(error_o), 64'(exp_err));
      chk("cfg_valid_o", 64'(cfg_valid_o), 64'(exp_q.size() != 0));
      chk("frame_ready_o", 64'(frame_ready_o), 64'(exp_q.size() == 0));
      if (cfg_valid_o && exp_q.size() != 0) begin
        chk("dma_type_o", 64'(dma_type_o), 64'(exp_q[0].t));
        chk("dma_id_o", 64'(dma_id_o), 64'(exp_q[0].id));
        chk("reader_addr_o", 64'(reader_addr_o), 64'(exp_q[0].ra));
        chk("writer_addr_o", 64'(writer_addr_o), 64'(exp_q[0].wa));
        chk("num_frames_o", 64'(num_frames_o), 64'(exp_q[0].n));
        chkp("payload_o", payload_o, exp_q[0].pay);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [DW-1:0] f);
    int n;
    @(negedge clk_i);
    frame_i = f;
    frame_valid_i = 1'b1;
    n = 0;
    while (!frame_ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (!frame_ready_o) chk("send_timeout", 64'(0), 64'(1));
    @(posedge clk_i);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      frame_valid_i = 1'b0;
    end
  endtask

  logic [FPW-1:0] pa, pe;
  logic [RPW-1:0] pb, pc, pd;
  logic [PW-1:0]  snap;
  int             e0, v0;

  initial begin
    pa = FPW'({52{8'hA1}});
    pb = RPW'({64{8'hB2}});
    pc = RPW'({64{8'hC3}});
    pd = RPW'({64{8'hD4}});
    pe = FPW'({52{8'hE5}});

    // Reset state
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_cfg_valid", 64'(cfg_valid_o), 64'(0));
    chk("rst_error", 64'(error_o), 64'(0));
    chk("rst_ready", 64'(frame_ready_o), 64'(1));
    chk("rst_id", 64'(dma_id_o), 64'(0));
    chk("rst_addrs", 64'({reader_addr_o[15:0], writer_addr_o[15:0], 3'b0, dma_type_o, num_frames_o}), 64'(0));
    chkp("rst_payload", payload_o, '0);

    // 1: single frame
    send(mk_first(1'b1, 4'd1, 4'h3, 48'h1000, 48'h2000, pa));
    idle(1);
    chk("t1_valid", 64'(cfg_valid_o), 64'(1));
    chk("t1_num", 64'(num_frames_o), 64'(1));
    chk("t1_type", 64'(dma_type_o), 64'(1));
    chk("t1_id", 64'(dma_id_o), 64'h3);
    chk("t1_reader", 64'(reader_addr_o), 64'h1000);
    chk("t1_writer", 64'(writer_addr_o), 64'h2000);
    chk("t1_upper_zero", 64'(payload_o[PW-1:FPW] == '0), 64'(1));
    chk("t1_low_pay", payload_o[63:0], pa[63:0]);
    idle(2);

    // 2: four frames with back-pressure
    cfg_ready_i = 1'b0;
    send(mk_first(1'b0, 4'd4, 4'h9, 48'hABCD_0000_1111, 48'h0000_FEED_2222, pa));
    send(mk_next(1'b0, 4'd4, pb));
    send(mk_next(1'b0, 4'd4, pc));
    send(mk_next(1'b0, 4'd4, pd));
    idle(1);
    snap = payload_o;
    chk("t2_slot0", payload_o[63:0], pa[63:0]);
    chk("t2_slot1", payload_o[FPW +: 64], pb[63:0]);
    chk("t2_slot2", payload_o[FPW + RPW +: 64], pc[63:0]);
    chk("t2_slot3_top", payload_o[PW-1 -: 64], pd[RPW-1 -: 64]);
    chk("t2_num", 64'(num_frames_o), 64'(4));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("t2_hold_ready", 64'(frame_ready_o), 64'(0));
      chkp("t2_hold_payload", payload_o, snap);
    end
    cfg_ready_i = 1'b1;
    @(negedge clk_i);
    chk("t2_released", 64'(cfg_valid_o), 64'(0));

    // 3: bad lengths
    e0 = err_seen;
    v0 = valid_seen;
    send(mk_first(1'b0, 4'd0, 4'h1, 48'h1, 48'h2, pa));
    send(mk_first(1'b0, 4'd5, 4'h1, 48'h1, 48'h2, pa));
    idle(3);
    chk("t3_errors", 64'(err_seen - e0), 64'(2));
    chk("t3_no_valid", 64'(valid_seen - v0), 64'(0));

    // 4: header mismatch, then clean single frame
    e0 = err_seen;
    send(mk_first(1'b1, 4'd3, 4'h2, 48'h10, 48'h20, pa));
    send(mk_next(1'b0, 4'd3, pb));
    idle(2);
    chk("t4_error", 64'(err_seen - e0), 64'(1));
    send(mk_first(1'b0, 4'd1, 4'h5, 48'h30, 48'h40, pe));
    idle(1);
    chk("t4_valid", 64'(cfg_valid_o), 64'(1));
    chk("t4_no_stale", 64'(payload_o[PW-1:FPW] == '0), 64'(1));
    chk("t4_id", 64'(dma_id_o), 64'h5);
    idle(2);

    // 5: reset mid-assembly
    send(mk_first(1'b1, 4'd4, 4'h7, 48'h50, 48'h60, pa));
    send(mk_next(1'b1, 4'd4, pb));
    @(negedge clk_i);
    frame_valid_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("t5_valid", 64'(cfg_valid_o), 64'(0));
    chk("t5_ready", 64'(frame_ready_o), 64'(1));
    chk("t5_hdr", 64'({dma_id_o, num_frames_o, 7'b0, dma_type_o, reader_addr_o[23:0], writer_addr_o[23:0]}), 64'(0));
    chkp("t5_payload", payload_o, '0);
    rst_i = 1'b0;
    send(mk_first(1'b1, 4'd2, 4'hC, 48'h70, 48'h80, pe));
    send(mk_next(1'b1, 4'd2, pc));
    idle(1);
    chk("t5_new_valid", 64'(cfg_valid_o), 64'(1));
    chk("t5_new_num", 64'(num_frames_o), 64'(2));
    chk("t5_new_slot1", payload_o[FPW +: 64], pc[63:0]);
    idle(2);

`ifdef XDMA_CFG_ASM_TIMEOUT_EN
    // 6: timeout, then a late frame starts a new configuration
    e0 = err_seen;
    send(mk_first(1'b0, 4'd2, 4'h1, 48'h90, 48'hA0, pa));
    idle(TMO + 3);
    chk("t6_timeout_error", 64'(err_seen - e0), 64'(1));
    send(mk_first(1'b1, 4'd1, 4'h6, 48'hB0, 48'hC0, pe));
    idle(1);
    chk("t6_late_valid", 64'(cfg_valid_o), 64'(1));
    chk("t6_late_id", 64'(dma_id_o), 64'h6);
    idle(2);
`endif

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
